pipeline_id_queue: RTL and testbench

Parametrised elastic successor to the single-entry IF/ID latch. It buffers up to DEPTH fetched {instruction, pc} pairs between the fetch and decode/issue logic using valid/ready handshakes on both sides. It detects load-use hazards on the head entry and holds it back, and it keeps a saturating bubble counter for performance analysis. A flush empties the whole queue in one cycle. It sits between the fetch unit and the ctrl/imm decode logic feeding EX.

---
 rtl/pipeline_id_queue.sv | 123 ++++++++++++
 tb/tb_pipeline_id_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_id_queue.sv
// ============================================================================
// Module   : pipeline_id_queue
// Brief    : Elastic IF/ID instruction queue with load-use hold and bubble count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_id_queue #(
   parameter int XLEN  = 64,
   parameter int ILEN  = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ILEN-1:0]              instruction_IF,
   input  logic [XLEN-1:0]              pc_IF,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ILEN-1:0]              instruction_ID,
   output logic [XLEN-1:0]              pc_ID,
   output logic [4:0]                   rd_ID,
   output logic [4:0]                   addr_reg_read_1,
   output logic [4:0]                   addr_reg_read_2,
   input  logic                         ex_load_valid,
   input  logic [4:0]                   ex_load_rd,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [CNT_W-1:0]             bubble_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0]   c_full_count = CW'(DEPTH);
   localparam logic [ILEN-1:0] c_nop        = ILEN'(32'h0000_0013);
   localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

   logic [ILEN-1:0] r_instr_mem [DEPTH];
   logic [XLEN-1:0] r_pc_mem    [DEPTH];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic [CNT_W-1:0] r_bubble;

   logic            w_empty;
   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic            w_hazard;
   logic [ILEN-1:0] w_head_instr;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_full_count);

   // Readiness ignores out_ready: a full queue never accepts, even while popping.
   assign in_ready  = !w_full && !flush;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   assign w_head_instr = w_empty ? c_nop : r_instr_mem[r_rd_ptr];
   assign w_rs1        = w_empty ? 5'd0 : w_head_instr[19:15];
   assign w_rs2        = w_empty ? 5'd0 : w_head_instr[24:20];

   assign w_hazard = ex_load_valid && (ex_load_rd != 5'd0) &&
                     ((ex_load_rd == w_rs1) || (ex_load_rd == w_rs2));

   assign out_valid       = !w_empty && !w_hazard && !flush;
   assign instruction_ID  = w_head_instr;
   assign pc_ID           = w_empty ? '0 : r_pc_mem[r_rd_ptr];
   assign rd_ID           = w_empty ? 5'd0 : w_head_instr[11:7];
   assign addr_reg_read_1 = w_rs1;
   assign addr_reg_read_2 = w_rs2;
   assign count           = r_count;
   assign bubble_cnt      = r_bubble;

   // Payload storage is deliberately left unreset; only control state is cleared.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr_mem[r_wr_ptr] <= instruction_IF;
         r_pc_mem[r_wr_ptr]    <= pc_IF;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Bubble counter survives flush so stall statistics span redirects.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bubble <= '0;
      end else if (!w_empty && w_hazard && !flush && (r_bubble != c_cnt_max)) begin
         r_bubble <= r_bubble + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_id_queue.sv
// ============================================================================
// Module   : tb_pipeline_id_queue
// Brief    : Directed self-checking bench for pipeline_id_queue
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipeline_id_queue;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] instruction_IF;
   logic [63:0] pc_IF;
   logic        ex_load_valid;
   logic [4:0]  ex_load_rd;

   logic        in_ready,  in_ready_s;
   logic        out_valid, out_valid_s;
   logic [31:0] instruction_ID, instruction_ID_s;
   logic [63:0] pc_ID, pc_ID_s;
   logic [4:0]  rd_ID, rd_ID_s;
   logic [4:0]  rs1, rs1_s;
   logic [4:0]  rs2, rs2_s;
   logic [2:0]  count, count_s;
   logic [15:0] bubble_cnt;
   logic [3:0]  bubble_cnt_s;

   int n_tests;
   int n_fail;

   pipeline_id_queue #(.XLEN(64), .ILEN(32), .DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instruction_IF(instruction_IF), .pc_IF(pc_IF),
      .out_valid(out_valid), .out_ready(out_ready),
      .instruction_ID(instruction_ID), .pc_ID(pc_ID), .rd_ID(rd_ID),
      .addr_reg_read_1(rs1), .addr_reg_read_2(rs2),
      .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
      .count(count), .bubble_cnt(bubble_cnt)
   );

   // Narrow-counter instance sharing the same stimulus, used for saturation.
   pipeline_id_queue #(.XLEN(64), .ILEN(32), .DEPTH(4), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_s),
      .instruction_IF(instruction_IF), .pc_IF(pc_IF),
      .out_valid(out_valid_s), .out_ready(out_ready),
      .instruction_ID(instruction_ID_s), .pc_ID(pc_ID_s), .rd_ID(rd_ID_s),
      .addr_reg_read_1(rs1_s), .addr_reg_read_2(rs2_s),
      .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
      .count(count_s), .bubble_cnt(bubble_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive at the falling edge, then let combinational outputs settle.
   task automatic mid_cycle();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instruction_IF = 32'h0; pc_IF = 64'h0;
      ex_load_valid = 1'b0; ex_load_rd = 5'd0;

      repeat (2) mid_cycle();
      settle();
      check("rst_count", count, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_instr_nop", instruction_ID, 32'h13);
      check("rst_pc", pc_ID, 0);
      check("rst_bubble", bubble_cnt, 0);
      reset = 1'b0;

      // Fill
      for (int i = 0; i < 4; i++) begin
         mid_cycle();
         in_valid = 1'b1;
         pc_IF = 64'h1000 + 64'(4 * i);
         instruction_IF = 32'h0000_0033 + 32'(i << 7);
      end
      mid_cycle();
      pc_IF = 64'h1010;
      settle();
      check("full_count", count, 4);
      check("full_in_ready", in_ready, 0);
      check("full_head_pc", pc_ID, 64'h1000);
      mid_cycle();
      in_valid = 1'b0;
      settle();
      check("fifth_rejected_count", count, 4);

      // Drain
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("drain_valid", out_valid, 1);
         check("drain_pc", pc_ID, 64'h1000 + 64'(4 * i));
         mid_cycle();
      end
      settle();
      check("drained_count", count, 0);
      check("drained_nop", instruction_ID, 32'h13);
      check("drained_out_valid", out_valid, 0);

      // Wrap-around streaming
      out_ready = 1'b0;
      in_valid = 1'b1; pc_IF = 64'h2000; instruction_IF = 32'h0000_0033;
      mid_cycle();
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         pc_IF = 64'h2004 + 64'(4 * k);
         settle();
         check("wrap_count", count, 1);
         check("wrap_pc", pc_ID, 64'h2000 + 64'(4 * k));
         mid_cycle();
      end
      in_valid = 1'b0;
      settle();
      check("wrap_last_pc", pc_ID, 64'h2028);
      mid_cycle();
      settle();
      check("wrap_empty", count, 0);

      // Load-use hazard: add x0,x1,x2 vs load to x2
      out_ready = 1'b0;
      in_valid = 1'b1; pc_IF = 64'h3000; instruction_IF = 32'h0020_8033;
      mid_cycle();
      in_valid = 1'b0;
      out_ready = 1'b1; ex_load_valid = 1'b1; ex_load_rd = 5'd2;
      settle();
      check("lu_rs1", rs1, 1);
      check("lu_rs2", rs2, 2);
      check("lu_rd", rd_ID, 0);
      for (int i = 0; i < 3; i++) begin
         settle();
         check("lu_stall", out_valid, 0);
         mid_cycle();
      end
      ex_load_rd = 5'd0;
      settle();
      check("lu_bubble", bubble_cnt, 3);
      check("lu_x0_no_stall", out_valid, 1);
      mid_cycle();
      ex_load_valid = 1'b0;
      settle();
      check("lu_popped", count, 0);
      check("lu_bubble_held", bubble_cnt, 3);

      // Saturation: hazard on rs1 for 20 more cycles
      out_ready = 1'b0;
      in_valid = 1'b1; pc_IF = 64'h4000; instruction_IF = 32'h0020_8033;
      mid_cycle();
      in_valid = 1'b0;
      out_ready = 1'b1; ex_load_valid = 1'b1; ex_load_rd = 5'd1;
      repeat (20) mid_cycle();
      ex_load_valid = 1'b0;
      settle();
      check("sat_narrow", bubble_cnt_s, 15);
      check("sat_wide", bubble_cnt, 23);
      check("sat_head_pc", pc_ID, 64'h4000);
      mid_cycle();

      // Flush with a concurrent offer
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; pc_IF = 64'h5000 + 64'(4 * i); instruction_IF = 32'h0000_0033;
         mid_cycle();
      end
      settle();
      check("pre_flush_count", count, 3);
      flush = 1'b1; pc_IF = 64'h500C;
      settle();
      check("flush_in_ready", in_ready, 0);
      check("flush_out_valid", out_valid, 0);
      mid_cycle();
      flush = 1'b0; in_valid = 1'b0;
      settle();
      check("post_flush_count", count, 0);
      check("post_flush_out_valid", out_valid, 0);
      check("post_flush_pc", pc_ID, 0);
      check("post_flush_bubble", bubble_cnt, 23);
      in_valid = 1'b1; pc_IF = 64'h6000;
      mid_cycle();
      settle();
      check("post_flush_head", pc_ID, 64'h6000);

      // Asynchronous reset between edges
      pc_IF = 64'h6004;
      mid_cycle();
      in_valid = 1'b0;
      settle();
      check("pre_rst_count", count, 2);
      #2 reset = 1'b1;
      #1;
      check("arst_count", count, 0);
      check("arst_out_valid", out_valid, 0);
      check("arst_bubble", bubble_cnt, 0);
      check("arst_bubble_narrow", bubble_cnt_s, 0);
      check("arst_in_ready", in_ready, 1);
      mid_cycle();
      reset = 1'b0;
      in_valid = 1'b1; pc_IF = 64'h7000;
      mid_cycle();
      in_valid = 1'b0;
      settle();
      check("first_push_count", count, 1);
      check("first_push_pc", pc_ID, 64'h7000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
